// File: rtl/q15_mul_arbiter.sv
// q15_mul_arbiter: two-channel round-robin Q1.15 multiplier, IDLE/MUL/OUT sequence.
// Latency: ack in cycle N -> q_x/q_valid_x in N+2; next ack no earlier than N+3.
// Backpressure: req_x holds until ack_x; requests raised while busy wait for IDLE.
// Define Q15_MUL_SATURATE_EN to clamp out-of-range results instead of wrapping.
module q15_mul_arbiter #(
    parameter int FRAC_BITS = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_0,
    input  logic               req_1,
    input  logic signed [15:0] a_0,
    input  logic signed [15:0] b_0,
    input  logic signed [15:0] a_1,
    input  logic signed [15:0] b_1,
    output logic               ack_0,
    output logic               ack_1,
    output logic signed [15:0] q_0,
    output logic signed [15:0] q_1,
    output logic               q_valid_0,
    output logic               q_valid_1,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        OUT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_ch;
    logic               gnt_ch;
    logic               sel_ch;
    logic               any_req;
    logic signed [31:0] prod;
    logic signed [31:0] prod_nxt;
    logic signed [31:0] shifted;
    logic signed [15:0] q_nxt;

    // On a tie the channel not served last wins; last_ch resets to 1 so channel 0 goes first.
    assign any_req  = req_0 | req_1;
    assign sel_ch   = (req_0 && req_1) ? ~last_ch : req_1;
    assign prod_nxt = sel_ch ? 32'(a_1) * 32'(b_1) : 32'(a_0) * 32'(b_0);
    assign shifted  = prod >>> FRAC_BITS;

`ifdef Q15_MUL_SATURATE_EN
    assign q_nxt = (shifted > 32'sd32767)  ? 16'sh7FFF :
                   (shifted < -32'sd32768) ? 16'sh8000 : shifted[15:0];
`else
    logic unused_hi;
    assign unused_hi = ^shifted[31:16];
    assign q_nxt     = shifted[15:0];
`endif

    always_comb begin
        state_nxt = state;
        ack_0     = 1'b0;
        ack_1     = 1'b0;
        q_valid_0 = 1'b0;
        q_valid_1 = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = MUL;
                    ack_0     = !reset && !sel_ch;
                    ack_1     = !reset && sel_ch;
                end
            end
            MUL: begin
                state_nxt = OUT;
                busy      = !reset;
            end
            OUT: begin
                state_nxt = IDLE;
                busy      = !reset;
                q_valid_0 = !reset && !gnt_ch;
                q_valid_1 = !reset && gnt_ch;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // q_x is loaded on the MUL->OUT edge so it is visible together with q_valid_x in OUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last_ch <= 1'b1;
            gnt_ch  <= 1'b0;
            prod    <= '0;
            q_0     <= '0;
            q_1     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                gnt_ch  <= sel_ch;
                last_ch <= sel_ch;
                prod    <= prod_nxt;
            end
            if (state == MUL) begin
                if (gnt_ch) q_1 <= q_nxt;
                else        q_0 <= q_nxt;
            end
        end
    end

endmodule

// File: tb/tb_q15_mul_arbiter.sv
// Testbench for q15_mul_arbiter: scenario tasks with a queue scoreboard of expected results.
module tb_q15_mul_arbiter;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_0, req_1;
    logic signed [15:0] a_0, b_0, a_1, b_1;
    logic               ack_0, ack_1;
    logic signed [15:0] q_0, q_1;
    logic               q_valid_0, q_valid_1;
    logic               busy;

    q15_mul_arbiter #(.FRAC_BITS(15)) dut (
        .clk(clk), .reset(reset), .req_0(req_0), .req_1(req_1),
        .a_0(a_0), .b_0(b_0), .a_1(a_1), .b_1(b_1),
        .ack_0(ack_0), .ack_1(ack_1), .q_0(q_0), .q_1(q_1),
        .q_valid_0(q_valid_0), .q_valid_1(q_valid_1), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        ch;
        logic [15:0] q;
        int          due;
    } exp_t;
    exp_t sb[$];

`ifdef Q15_MUL_SATURATE_EN
    localparam logic [15:0] OVF_Q = 16'h7FFF;
`else
    localparam logic [15:0] OVF_Q = 16'h8000;
`endif

    function automatic logic [15:0] model_q(logic signed [15:0] a, logic signed [15:0] b);
        logic signed [31:0] p;
        logic signed [31:0] s;
        p = 32'(a) * 32'(b);
        s = p >>> 15;
`ifdef Q15_MUL_SATURATE_EN
        if (s > 32'sd32767) return 16'h7FFF;
        if (s < -32'sd32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    task automatic wait_ack(output logic ch, output int c, output bit to);
        to = 1'b1; ch = 1'b0; c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ack_0 || ack_1) begin
                ch = ack_1; c = cyc; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_qv(output logic ch, output logic [15:0] q, output int c, output bit to);
        to = 1'b1; ch = 1'b0; q = '0; c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q_valid_0 || q_valid_1) begin
                ch = q_valid_1; q = q_valid_1 ? q_1 : q_0; c = cyc; to = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset(int n);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_0 = 1'b0; req_1 = 1'b0;
        a_0 = '0; b_0 = '0; a_1 = '0; b_1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({q_0, q_1} !== 32'h0) begin
            n_fail++; $display("FAIL reset_q: got q_0=%h q_1=%h, want 0000 0000", q_0, q_1);
        end
        n_checks++;
        if ({ack_0, ack_1, busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got ack_0=%b ack_1=%b busy=%b, want 000", ack_0, ack_1, busy);
        end
        n_checks++;
        if ({q_valid_0, q_valid_1} !== 2'b00) begin
            n_fail++; $display("FAIL reset_qv: got %b%b, want 00", q_valid_0, q_valid_1);
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic test_basic;
        logic ch; logic [15:0] q; int n, c; bit to; exp_t e;
        a_0 = 16'sh4000; b_0 = 16'sh4000; req_0 = 1'b1;
        wait_ack(ch, n, to);
        n_checks++;
        if (to || ch !== 1'b0) begin
            n_fail++; $display("FAIL basic_ack: timeout=%0d ch=%0d, want ack_0", to, ch); return;
        end
        sb.push_back('{1'b0, 16'h2000, n + 2});
        @(posedge clk); #1 req_0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || ack_0 !== 1'b0) begin
            n_fail++; $display("FAIL basic_busy_n1: got busy=%b ack_0=%b, want 1 0", busy, ack_0);
        end
        wait_qv(ch, q, c, to);
        n_checks++;
        if (to) begin
            n_fail++; $display("FAIL basic_qv: no q_valid within bound"); void'(sb.pop_front()); return;
        end
        e = sb.pop_front();
        if (ch !== e.ch || q !== e.q || c !== e.due || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_result: got ch%0d q=%h cyc=%0d busy=%b, want ch%0d q=%h cyc=%0d busy=1",
                     ch, q, c, busy, e.ch, e.q, e.due);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || q_valid_0 !== 1'b0 || q_0 !== 16'sh2000) begin
            n_fail++;
            $display("FAIL basic_after: got busy=%b q_valid_0=%b q_0=%h, want 0 0 2000", busy, q_valid_0, q_0);
        end
    endtask

    task automatic test_arbitration;
        logic ch; logic [15:0] q; int n, n2, c; bit to; exp_t e;
        do_reset(2);
        a_0 = 16'sh4000; b_0 = 16'sh4000; a_1 = 16'sh7FFF; b_1 = 16'sh7FFF;
        req_0 = 1'b1; req_1 = 1'b1;
        wait_ack(ch, n, to);
        n_checks++;
        if (to || ch !== 1'b0 || ack_1 !== 1'b0) begin
            n_fail++; $display("FAIL arb_first: timeout=%0d ch=%0d ack_1=%b, want ch0 only", to, ch, ack_1);
            req_0 = 1'b0; req_1 = 1'b0; return;
        end
        sb.push_back('{1'b0, 16'h2000, n + 2});
        @(posedge clk); #1 req_0 = 1'b0;
        wait_qv(ch, q, c, to);
        n_checks++;
        e = sb.pop_front();
        if (to || ch !== e.ch || q !== e.q || c !== e.due) begin
            n_fail++; $display("FAIL arb_res0: got ch%0d q=%h cyc=%0d, want ch%0d q=%h cyc=%0d", ch, q, c, e.ch, e.q, e.due);
        end
        wait_ack(ch, n2, to);
        n_checks++;
        if (to || ch !== 1'b1 || n2 !== n + 3) begin
            n_fail++; $display("FAIL arb_second: got ch%0d cyc=%0d, want ch1 cyc=%0d", ch, n2, n + 3);
            req_1 = 1'b0; return;
        end
        sb.push_back('{1'b1, 16'h7FFE, n2 + 2});
        @(posedge clk); #1 req_1 = 1'b0;
        wait_qv(ch, q, c, to);
        n_checks++;
        e = sb.pop_front();
        if (to || ch !== e.ch || q !== e.q || c !== e.due || q_0 !== 16'sh2000) begin
            n_fail++;
            $display("FAIL arb_res1: got ch%0d q=%h cyc=%0d q_0=%h, want ch%0d q=%h cyc=%0d q_0=2000",
                     ch, q, c, q_0, e.ch, e.q, e.due);
        end
    endtask

    task automatic test_negative;
        logic ch; logic [15:0] q; int n, c; bit to; exp_t e;
        a_1 = 16'shC000; b_1 = 16'sh4000; req_1 = 1'b1;
        wait_ack(ch, n, to);
        sb.push_back('{1'b1, 16'hE000, n + 2});
        @(posedge clk); #1 req_1 = 1'b0;
        wait_qv(ch, q, c, to);
        n_checks++;
        e = sb.pop_front();
        if (to || ch !== e.ch || q !== e.q || c !== e.due || q_0 !== 16'sh2000) begin
            n_fail++;
            $display("FAIL neg_quarter: got ch%0d q=%h cyc=%0d q_0=%h, want ch%0d q=%h cyc=%0d q_0=2000",
                     ch, q, c, q_0, e.ch, e.q, e.due);
        end
        a_0 = 16'shFFFF; b_0 = 16'sh0001; req_0 = 1'b1;
        wait_ack(ch, n, to);
        sb.push_back('{1'b0, 16'hFFFF, n + 2});
        @(posedge clk); #1 req_0 = 1'b0;
        wait_qv(ch, q, c, to);
        n_checks++;
        e = sb.pop_front();
        if (to || ch !== e.ch || q !== e.q || c !== e.due || q_1 !== 16'shE000) begin
            n_fail++;
            $display("FAIL neg_floor: got ch%0d q=%h cyc=%0d q_1=%h, want ch%0d q=%h cyc=%0d q_1=e000",
                     ch, q, c, q_1, e.ch, e.q, e.due);
        end
    endtask

    task automatic test_overflow;
        logic ch; logic [15:0] q; int n, c; bit to; exp_t e;
        a_0 = 16'sh8000; b_0 = 16'sh8000; req_0 = 1'b1;
        wait_ack(ch, n, to);
        sb.push_back('{1'b0, OVF_Q, n + 2});
        @(posedge clk); #1 req_0 = 1'b0;
        wait_qv(ch, q, c, to);
        n_checks++;
        e = sb.pop_front();
        if (to || ch !== e.ch || q !== e.q || c !== e.due) begin
            n_fail++; $display("FAIL overflow: got ch%0d q=%h cyc=%0d, want ch%0d q=%h cyc=%0d", ch, q, c, e.ch, e.q, e.due);
        end
    endtask

    task automatic test_reset_abort;
        logic ch; logic [15:0] q; int n, c; bit to; exp_t e;
        a_0 = 16'sh4000; b_0 = 16'sh4000; req_0 = 1'b1;
        wait_ack(ch, n, to);
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (q_valid_0 !== 1'b0 || busy !== 1'b0 || ack_0 !== 1'b0) begin
            n_fail++; $display("FAIL abort_in_reset: got q_valid_0=%b busy=%b ack_0=%b, want 000", q_valid_0, busy, ack_0);
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (q_0 !== 16'sh0000 || q_valid_0 !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_after: got q_0=%h q_valid_0=%b busy=%b, want 0000 0 0", q_0, q_valid_0, busy);
        end
        n_checks++;
        if (ack_0 !== 1'b1) begin
            n_fail++; $display("FAIL abort_regrant: got ack_0=%b, want 1", ack_0);
            req_0 = 1'b0; return;
        end
        sb.push_back('{1'b0, 16'h2000, cyc + 2});
        @(posedge clk); #1 req_0 = 1'b0;
        wait_qv(ch, q, c, to);
        n_checks++;
        e = sb.pop_front();
        if (to || ch !== e.ch || q !== e.q || c !== e.due) begin
            n_fail++; $display("FAIL abort_result: got ch%0d q=%h cyc=%0d, want ch%0d q=%h cyc=%0d", ch, q, c, e.ch, e.q, e.due);
        end
    endtask

    task automatic test_back_to_back;
        logic ch, prev_ch; logic [15:0] q; int n, prev_n, c; bit to; exp_t e;
        a_0 = 16'($urandom_range(0, 65535)); b_0 = 16'($urandom_range(0, 65535));
        a_1 = 16'($urandom_range(0, 65535)); b_1 = 16'($urandom_range(0, 65535));
        req_0 = 1'b1; req_1 = 1'b1;
        prev_ch = 1'b0; prev_n = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(ch, n, to);
            if (to) begin
                n_checks++; n_fail++; $display("FAIL b2b_ack: no ack within bound at k=%0d", k);
                break;
            end
            if (k > 0) begin
                n_checks++;
                if (n - prev_n !== 3 || ch === prev_ch) begin
                    n_fail++;
                    $display("FAIL b2b_rr: got ch%0d gap=%0d, want ch%0d gap=3", ch, n - prev_n, !prev_ch);
                end
            end
            sb.push_back('{ch, ch ? model_q(a_1, b_1) : model_q(a_0, b_0), n + 2});
            prev_ch = ch; prev_n = n;
            @(posedge clk); #1;
            if (k == 3) begin req_0 = 1'b0; req_1 = 1'b0; end
            wait_qv(ch, q, c, to);
            n_checks++;
            e = sb.pop_front();
            if (to || ch !== e.ch || q !== e.q || c !== e.due) begin
                n_fail++; $display("FAIL b2b_result: got ch%0d q=%h cyc=%0d, want ch%0d q=%h cyc=%0d", ch, q, c, e.ch, e.q, e.due);
            end
        end
        req_0 = 1'b0; req_1 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_arbitration;
        test_negative;
        test_overflow;
        test_reset_abort;
        test_back_to_back;
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
